regfile_legv8: RTL and testbench

REGFILE_LEGV8 -- requirements
Module: regfile_legv8

---
 rtl/regfile_legv8_pkg.sv | 21 ++
 rtl/regfile_legv8_status_reg.sv | 34 +++
 rtl/regfile_legv8.sv | 80 ++++++++
 tb/tb_regfile_legv8.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_legv8_pkg.sv
// ----------------------------------------------------------------------------
// regfile_legv8_pkg
// Shared constants for the LEGv8 register file:
//   DATA_WIDTH  - register / bus width
//   REG_ADDR_W  - register address width (32 registers)
//   XZR         - address of the hard-wired zero register
//   ST_V/C/N/Z  - bit positions of the flags inside the 4-bit status word
// ----------------------------------------------------------------------------
package regfile_legv8_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int REG_ADDR_W = 5;

   localparam logic [4:0] XZR = 5'd31;

   localparam int ST_V = 3;
   localparam int ST_C = 2;
   localparam int ST_N = 1;
   localparam int ST_Z = 0;

endpackage : regfile_legv8_pkg

// File: rtl/regfile_legv8_status_reg.sv
// ----------------------------------------------------------------------------
// status_reg
// 4-bit flag register {V,C,N,Z} with load enable and synchronous reset.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-high clear (wins over i_load)
//   i_load  - load i_d on the next rising edge
//   i_d     - flags from the ALU
//   o_q     - latched flags
// ----------------------------------------------------------------------------
module status_reg
   import regfile_legv8_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       i_load,
   input  logic [3:0] i_d,
   output logic [3:0] o_q
);

   logic [3:0] r_flags;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_flags <= 4'b0000;
      end else if (i_load) begin
         r_flags <= i_d;
      end
   end

   // Re-pack by named index so the flag order lives in one place.
   assign o_q = {r_flags[ST_V], r_flags[ST_C], r_flags[ST_N], r_flags[ST_Z]};

endmodule : status_reg

// File: rtl/regfile_legv8.sv
// ----------------------------------------------------------------------------
// regfile_legv8
// LEGv8 datapath register file: 32 x DATA_WIDTH registers with two
// combinational read ports, one synchronous write port with write-through
// bypass, a hard-wired zero register (X31 / XZR) and the NZCV status latch.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   SA, SB        - read addresses for ports A and B
//   DA, W, D      - write address, write enable, write data
//   A, B          - read data (zero-latency, bypassed from D on a hit)
//   status_in, SL - ALU flags {V,C,N,Z} and their load enable
//   status        - latched flags {V,C,N,Z}
// ----------------------------------------------------------------------------
module regfile_legv8 #(
   parameter int DATA_WIDTH = regfile_legv8_pkg::DATA_WIDTH,
   parameter int REG_ADDR_W = regfile_legv8_pkg::REG_ADDR_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] SA,
   input  logic [REG_ADDR_W-1:0] SB,
   input  logic [REG_ADDR_W-1:0] DA,
   input  logic                  W,
   input  logic [DATA_WIDTH-1:0] D,
   output logic [DATA_WIDTH-1:0] A,
   output logic [DATA_WIDTH-1:0] B,
   input  logic [3:0]            status_in,
   input  logic                  SL,
   output logic [3:0]            status
);

   import regfile_legv8_pkg::*;

   localparam int                  NREGS  = 2 ** REG_ADDR_W;
   localparam logic [REG_ADDR_W-1:0] L_XZR = REG_ADDR_W'(XZR);

   logic [DATA_WIDTH-1:0] r_x [NREGS];
   logic                  w_wr_en;

   // XZR is never written, so a write aimed at it is simply dropped here.
   assign w_wr_en = W && (DA != L_XZR);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_x[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_x[DA] <= D;
      end
   end

   // Read port: zero for XZR, then same-cycle bypass of the pending write,
   // else the stored value. The bypass ignores reset on purpose so the ALU
   // sees D while reset is held; the XZR test also masks r_x[31], which is
   // never written and may be uninitialised before the first reset.
   function automatic logic [DATA_WIDTH-1:0] read_port(
      input logic [REG_ADDR_W-1:0] addr,
      input logic [DATA_WIDTH-1:0] stored
   );
      if (addr == L_XZR)
         return '0;
      else if (w_wr_en && (DA == addr))
         return D;
      else
         return stored;
   endfunction

   assign A = read_port(SA, r_x[SA]);
   assign B = read_port(SB, r_x[SB]);

   status_reg u_status_reg (
      .clock  (clock),
      .reset  (reset),
      .i_load (SL),
      .i_d    (status_in),
      .o_q    (status)
   );

endmodule : regfile_legv8

// File: tb/tb_regfile_legv8.sv
// ----------------------------------------------------------------------------
// tb_regfile_legv8
// Directed bench for regfile_legv8. A behavioural model (plain array plus
// flag word) is updated on every rising edge; a compare process checks A, B
// and status against it on every falling edge. The directed sequence adds
// hand-computed literal expectations on top.
// ----------------------------------------------------------------------------
module tb_regfile_legv8;

   localparam int DW = 64;
   localparam int AW = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] SA, SB, DA;
   logic          W;
   logic [DW-1:0] D;
   logic [DW-1:0] A, B;
   logic [3:0]    status_in;
   logic          SL;
   logic [3:0]    status;

   int errors = 0;
   int checks = 0;

   regfile_legv8 #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
      .clock     (clock),
      .reset     (reset),
      .SA        (SA),
      .SB        (SB),
      .DA        (DA),
      .W         (W),
      .D         (D),
      .A         (A),
      .B         (B),
      .status_in (status_in),
      .SL        (SL),
      .status    (status)
   );

   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_x [32];
   logic [3:0]    m_st;
   bit            m_valid = 1'b0;

   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) m_x[i] = '0;
         m_st = 4'b0000;
      end else begin
         if (W && DA != 5'd31) m_x[DA] = D;
         if (SL) m_st = status_in;
      end
   end

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
      if (addr == 5'd31) return '0;
      if (W && DA == addr) return D;
      return m_x[addr];
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (m_valid) begin
         chk("model_A", A, model_read(SA));
         chk("model_B", B, model_read(SB));
         chk("model_status", {60'd0, status}, {60'd0, m_st});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic look();
      @(negedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; W = 1'b0; SL = 1'b0;
      SA = '0; SB = '0; DA = '0; D = '0; status_in = 4'b0000;

      // Reset for one edge, then sweep every readable address.
      cyc();
      reset = 1'b0;
      m_valid = 1'b1;
      for (int i = 0; i < 31; i++) begin
         SA = AW'(i);
         SB = AW'(30 - i);
         look();
         chk("rst_A_sweep", A, 64'h0);
         chk("rst_B_sweep", B, 64'h0);
      end
      chk("rst_status", {60'd0, status}, 64'h0);

      // Write X5=6, X6=3, then read both.
      cyc();
      W = 1'b1; DA = 5'd5; D = 64'h6;
      cyc();
      DA = 5'd6; D = 64'h3;
      cyc();
      W = 1'b0; SA = 5'd5; SB = 5'd6;
      look();
      chk("wr_rd_A_X5", A, 64'h6);
      chk("wr_rd_B_X6", B, 64'h3);

      // XZR: write discarded, bypass suppressed in the write cycle.
      cyc();
      W = 1'b1; DA = 5'd31; D = 64'hFFFF_FFFF_FFFF_FFFF; SA = 5'd31; SB = 5'd31;
      look();
      chk("xzr_bypass_A", A, 64'h0);
      chk("xzr_bypass_B", B, 64'h0);
      cyc();
      W = 1'b0;
      look();
      chk("xzr_read_A", A, 64'h0);

      // Bypass: DA=SA=SB=7.
      cyc();
      W = 1'b1; DA = 5'd7; SA = 5'd7; SB = 5'd7; D = 64'h8000_0000_0000_0000;
      look();
      chk("bypass_A", A, 64'h8000_0000_0000_0000);
      chk("bypass_B", B, 64'h8000_0000_0000_0000);
      cyc();
      W = 1'b0; D = 64'h0;
      look();
      chk("bypass_held_X7", A, 64'h8000_0000_0000_0000);
      // Bypass on one port only: A from D, B from storage.
      cyc();
      W = 1'b1; DA = 5'd5; SA = 5'd5; SB = 5'd6; D = 64'hDEAD_BEEF;
      look();
      chk("bypass_onlyA_A", A, 64'hDEAD_BEEF);
      chk("bypass_onlyA_B", B, 64'h3);

      // Status load and hold.
      cyc();
      W = 1'b0; SL = 1'b1; status_in = 4'b0110;
      cyc();
      SL = 1'b0; status_in = 4'b1001;
      look();
      chk("status_load", {60'd0, status}, 64'h6);
      cyc();
      look();
      chk("status_hold", {60'd0, status}, 64'h6);

      // W and SL in the same edge.
      cyc();
      W = 1'b1; DA = 5'd9; D = 64'h0ABC; SL = 1'b1; status_in = 4'b1010;
      cyc();
      W = 1'b0; SL = 1'b0; SA = 5'd9; SB = 5'd5; D = 64'h1111;
      look();
      chk("w_sl_X9", A, 64'h0ABC);
      chk("w_sl_X5", B, 64'hDEAD_BEEF);
      chk("w_sl_status", {60'd0, status}, 64'hA);
      // W=0 leaves X9 alone even with DA pointing at it.
      DA = 5'd9;
      cyc();
      look();
      chk("no_write_X9", A, 64'h0ABC);

      // Preload X3, then reset with competing W/SL.
      cyc();
      W = 1'b1; DA = 5'd3; D = 64'h1234;
      cyc();
      reset = 1'b1; W = 1'b1; DA = 5'd3; D = 64'h55; SL = 1'b1;
      status_in = 4'b1111; SA = 5'd3; SB = 5'd9;
      look();
      chk("rst_bypass_A", A, 64'h55);
      chk("rst_pre_B_X9", B, 64'h0ABC);
      cyc();
      W = 1'b0; SL = 1'b0;
      look();
      chk("rst_held_A", A, 64'h0);
      chk("rst_held_B", B, 64'h0);
      cyc();
      reset = 1'b0;
      look();
      chk("rst_prio_X3", A, 64'h0);
      chk("rst_prio_status", {60'd0, status}, 64'h0);

      // Pseudo-random traffic, checked by the model process only.
      for (int n = 0; n < 200; n++) begin
         cyc();
         reset     = ($urandom_range(0, 31) == 0);
         W         = $urandom_range(0, 1) == 1;
         SL        = $urandom_range(0, 3) == 0;
         DA        = AW'($urandom_range(0, 31));
         SA        = ($urandom_range(0, 3) == 0) ? DA : AW'($urandom_range(0, 31));
         SB        = ($urandom_range(0, 3) == 0) ? SA : AW'($urandom_range(0, 31));
         D         = {$urandom, $urandom};
         status_in = 4'($urandom_range(0, 15));
      end
      cyc();
      reset = 1'b0; W = 1'b0; SL = 1'b0;
      look();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_regfile_legv8
